distance_display_ctrl: RTL and testbench



---
 rtl/distance_pkg.sv | 37 +++
 rtl/distance_display_ctrl_bcd.sv | 85 ++++++++
 rtl/distance_display_ctrl.sv | 136 +++++++++++++
 tb/tb_distance_display_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/distance_pkg.sv
// Shared widths, default thresholds and converter state encoding for the
// distance display controller.
package distance_pkg;

    localparam int DIST_W = 9;
    localparam int BCD_W  = 12;

    localparam int DEF_MAX_CM  = 400;
    localparam int DEF_NEAR_CM = 20;
    localparam int DEF_HYST_CM = 5;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    function automatic logic [DIST_W-1:0] median3(
        input logic [DIST_W-1:0] a,
        input logic [DIST_W-1:0] b,
        input logic [DIST_W-1:0] c
    );
        logic [DIST_W-1:0] lo;
        logic [DIST_W-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c <= lo) begin
            return lo;
        end else if (c >= hi) begin
            return hi;
        end else begin
            return c;
        end
    endfunction

endpackage

// File: rtl/distance_display_ctrl_bcd.sv
// Sequential double-dabble: one bit per cycle, digits registered and
// announced with a one-cycle done pulse. Reset aborts a conversion silently.
module bin_to_bcd_seq
    import distance_pkg::*;
#(
    parameter int BIN_W = DIST_W,
    parameter int OUT_W = BCD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic [OUT_W-1:0] bcd,
    output logic             done
);

    localparam int DIGITS = OUT_W / 4;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    conv_state_t      state;
    conv_state_t      state_nxt;
    logic [BIN_W-1:0] shreg;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_adj;
    logic [CNT_W-1:0] iter;
    logic             last_iter;

    function automatic logic [OUT_W-1:0] dabble(input logic [OUT_W-1:0] v);
        logic [OUT_W-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (r[d*4 +: 4] >= 4'd5) begin
                r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign acc_adj   = dabble(acc);
    assign last_iter = (iter == CNT_W'(BIN_W - 1));
    assign busy      = (state != CONV_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE:  if (start) state_nxt = CONV_LOAD;
            CONV_LOAD:  state_nxt = CONV_SHIFT;
            CONV_SHIFT: if (last_iter) state_nxt = CONV_DONE;
            CONV_DONE:  state_nxt = CONV_IDLE;
            default:    state_nxt = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CONV_IDLE;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == CONV_DONE);
            if (state == CONV_DONE) begin
                bcd <= acc;
            end
        end
    end

    // Working registers are fully initialised in LOAD, so they carry no reset.
    always_ff @(posedge clk) begin
        case (state)
            CONV_LOAD: begin
                shreg <= bin;
                acc   <= '0;
                iter  <= '0;
            end
            CONV_SHIFT: begin
                {acc, shreg} <= {acc_adj, shreg} << 1;
                iter         <= iter + CNT_W'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/distance_display_ctrl.sv
// Samples the raw ranging distance, median-filters and clamps it, drives a
// hysteretic proximity alarm and feeds a sequential BCD converter.
module distance_display_ctrl
    import distance_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 50_000_000,
    parameter int MAX_CM        = DEF_MAX_CM,
    parameter int NEAR_CM       = DEF_NEAR_CM,
    parameter int HYST_CM       = DEF_HYST_CM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIST_W-1:0] distance,
    output logic [DIST_W-1:0] filt_cm,
    output logic              over_range,
    output logic              alarm,
    output logic [3:0]        bcd_hund,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_ones,
    output logic              bcd_valid
);

    if (MAX_CM < 0 || MAX_CM > 511 || NEAR_CM + HYST_CM > 511 || SAMPLE_CYCLES < 1) begin : g_param_check
        $error("distance_display_ctrl: thresholds must fit 9 bits and SAMPLE_CYCLES >= 1");
    end

    localparam int                PER_W    = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [PER_W-1:0]  PER_LAST = PER_W'(SAMPLE_CYCLES - 1);
    localparam logic [DIST_W-1:0] MAX_V    = DIST_W'(MAX_CM);
    localparam logic [DIST_W-1:0] NEAR_V   = DIST_W'(NEAR_CM);
    localparam logic [DIST_W-1:0] CLEAR_V  = DIST_W'(NEAR_CM + HYST_CM);

    function automatic logic [DIST_W-1:0] clamp_max(input logic [DIST_W-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    logic [DIST_W-1:0] dist_q;
    logic [PER_W-1:0]  per_cnt;
    logic              vld_p0;
    logic [DIST_W-1:0] w0;
    logic [DIST_W-1:0] w1;
    logic [DIST_W-1:0] w2;
    logic [1:0]        fill;
    logic              vld_p1;
    logic [DIST_W-1:0] filt_raw;
    logic [DIST_W-1:0] filt_nxt;
    logic              pending;
    logic              conv_start;
    logic              conv_busy;
    logic [BCD_W-1:0]  conv_bcd;

    // Stage 0: change or period expiry produces exactly one sample
    assign vld_p0 = (distance != dist_q) || (per_cnt == PER_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            dist_q  <= '0;
            per_cnt <= '0;
            w0      <= '0;
            w1      <= '0;
            w2      <= '0;
            fill    <= '0;
            vld_p1  <= 1'b0;
        end else begin
            dist_q <= distance;
            vld_p1 <= 1'b0;
            if (vld_p0) begin
                per_cnt <= '0;
                // Zero means "no echo": the sample is consumed but not filtered.
                if (distance != '0) begin
                    w0     <= distance;
                    w1     <= w0;
                    w2     <= w1;
                    vld_p1 <= 1'b1;
                    if (fill != 2'd3) begin
                        fill <= fill + 2'd1;
                    end
                end
            end else begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end

    // Stage 1: median / clamp / alarm, registered on window updates only
    assign filt_raw = (fill == 2'd3) ? median3(w0, w1, w2) : w0;
    assign filt_nxt = clamp_max(filt_raw);

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cm    <= '0;
            over_range <= 1'b0;
            alarm      <= 1'b0;
        end else if (vld_p1) begin
            filt_cm    <= filt_nxt;
            over_range <= (filt_raw > MAX_V);
            if (filt_nxt < NEAR_V) begin
                alarm <= 1'b1;
            end else if (filt_nxt >= CLEAR_V) begin
                alarm <= 1'b0;
            end
        end
    end

    // Stage 2: converter starts on the edge filt_cm loads, so LOAD sees the new value.
    // Updates during a conversion collapse into one follow-up conversion.
    assign conv_start = vld_p1 || pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (vld_p1 && conv_busy) begin
            pending <= 1'b1;
        end else if (!conv_busy) begin
            pending <= 1'b0;
        end
    end

    bin_to_bcd_seq #(
        .BIN_W (DIST_W),
        .OUT_W (BCD_W)
    ) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (filt_cm),
        .busy  (conv_busy),
        .bcd   (conv_bcd),
        .done  (bcd_valid)
    );

    assign bcd_hund = conv_bcd[11:8];
    assign bcd_tens = conv_bcd[7:4];
    assign bcd_ones = conv_bcd[3:0];

endmodule

// File: tb/tb_distance_display_ctrl.sv
// Scoreboard bench: directed distance sequences push expected conversions,
// a negedge monitor pops and checks each bcd_valid pulse.
module tb_distance_display_ctrl;
    import distance_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DIST_W-1:0] distance = '0;
    logic [DIST_W-1:0] filt_cm;
    logic              over_range;
    logic              alarm;
    logic [3:0]        bcd_hund;
    logic [3:0]        bcd_tens;
    logic [3:0]        bcd_ones;
    logic              bcd_valid;

    distance_display_ctrl #(
        .SAMPLE_CYCLES (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .distance   (distance),
        .filt_cm    (filt_cm),
        .over_range (over_range),
        .alarm      (alarm),
        .bcd_hund   (bcd_hund),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones),
        .bcd_valid  (bcd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int hund;
        int tens;
        int ones;
        int filt;
        int ovr;
        int alm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t0       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_filt_cm"}, filt_cm, 0);
        chk({tag, "_over_range"}, over_range, 0);
        chk({tag, "_alarm"}, alarm, 0);
        chk({tag, "_bcd"}, {bcd_hund, bcd_tens, bcd_ones}, 0);
        chk({tag, "_bcd_valid"}, bcd_valid, 0);
    endtask

    // conv: value the converter encodes; filt: filt_cm seen alongside bcd_valid
    task automatic exp_bcd(input int off, input int conv, input int filt, input int ovr, input int alm);
        exp_t e;
        e.cyc  = t0 + off;
        e.hund = conv / 100;
        e.tens = (conv / 10) % 10;
        e.ones = conv % 10;
        e.filt = filt;
        e.ovr  = ovr;
        e.alm  = alm;
        sb.push_back(e);
    endtask

    task automatic put(input int v);
        @(posedge clk);
        #1;
        distance = DIST_W'(v);
        t0 = cyc;
    endtask

    task automatic hold(input int n);
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        distance = '0;
        @(posedge clk);
        @(negedge clk);
        chk_zero(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Value held long enough for the change sample plus two periodic samples
    task automatic run3(input int v, input int f1, input int a1, input int f2, input int a2,
                        input int f3, input int a3);
        put(v);
        exp_bcd(13, f1, f1, 0, a1);
        exp_bcd(113, f2, f2, 0, a2);
        exp_bcd(213, f3, f3, 0, a3);
        hold(250);
    endtask

    always @(negedge clk) begin
        if (bcd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL bcd_valid_unexpected actual=1 required=0 cycle=%0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("bcd_valid_cycle", cyc, mon_e.cyc);
                chk("bcd_hund", bcd_hund, mon_e.hund);
                chk("bcd_tens", bcd_tens, mon_e.tens);
                chk("bcd_ones", bcd_ones, mon_e.ones);
                chk("filt_cm", filt_cm, mon_e.filt);
                chk("over_range", over_range, mon_e.ovr);
                chk("alarm", alarm, mon_e.alm);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk_zero("zero_input");
        chk("fill_after_zero", dut.fill, 0);

        put(100); exp_bcd(13, 100, 100, 0, 0); hold(20);
        put(300); exp_bcd(13, 300, 300, 0, 0); hold(20);
        put(102); exp_bcd(13, 102, 102, 0, 0); hold(20);
        pulse_reset("reset_after_seq");

        put(450);
        exp_bcd(13, 400, 400, 1, 0);
        @(negedge clk);
        @(negedge clk);
        chk("filt_before_edge2", filt_cm, 0);
        @(negedge clk);
        chk("filt_at_edge2", filt_cm, 400);
        chk("over_range_at_edge2", over_range, 1);
        hold(20);

        run3(30, 30, 0, 30, 0, 30, 0);
        run3(19, 30, 0, 19, 1, 19, 1);
        run3(22, 19, 1, 22, 1, 22, 1);
        run3(24, 22, 1, 24, 1, 24, 1);
        run3(25, 24, 1, 25, 0, 25, 0);

        run3(360, 25, 0, 360, 0, 360, 0);
        put(361);
        exp_bcd(13, 360, 348, 0, 0);
        exp_bcd(25, 348, 348, 0, 0);
        hold(3);
        put(347);
        hold(3);
        put(348);
        hold(40);

        put(150);
        exp_bcd(13, 347, 347, 0, 0);
        exp_bcd(113, 150, 150, 0, 0);
        exp_bcd(213, 150, 150, 0, 0);
        repeat (305) @(posedge clk);
        #1;
        reset = 1'b1;
        distance = '0;
        @(posedge clk);
        @(negedge clk);
        chk_zero("reset_in_shift");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk_zero("idle_after_abort");
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
